// File: rtl/multicycle_control_m_pkg.sv
// multicycle_control_m_pkg
//   Shared definitions for the LEGv8 multicycle sequencing controller:
//   state encodings, the default retired-counter width and the branch
//   resolution helper. Imported by the controller and by its bench.
package multicycle_control_m_pkg;

  // Encodings are visible on the controller's state port, so they are fixed.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 32;

  // Taken when the branch is unconditional, or conditional with a zero result.
  // CBNZ polarity is already folded into alu_zero by the datapath.
  function automatic logic branch_taken(input logic uncond,
                                        input logic branch,
                                        input logic zero);
    return uncond | (branch & zero);
  endfunction

endpackage

// File: rtl/multicycle_control_m.sv
// multicycle_control_m
//   Multicycle sequencer for the LEGv8 core: walks each instruction through
//   FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, stalling on memory ready
//   handshakes, and counts retired instructions.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   imem_ready, dmem_ready     memory handshakes (word valid / access done)
//   halt_req                   stop at the next instruction boundary
//   Uncondbranch .. RegWrite   decoder flags, stable while IR holds the word
//   alu_zero                   ALU zero flag
//   imem_req, ir_write,
//   exec_en, dmem_read,
//   dmem_write, reg_write_en,
//   pc_write                   combinational per-cycle enables
//   pc_src                     registered: 0 = PC+4, 1 = branch target
//   state                      current state encoding
//   retired                    registered retired-instruction count (wraps)
//   halted                     registered: controller is in HALT
module multicycle_control_m
  import multicycle_control_m_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   halt_req,
  input  logic                   Uncondbranch,
  input  logic                   Branch,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic                   MemtoReg,
  input  logic                   RegWrite,
  input  logic                   alu_zero,
  output logic                   imem_req,
  output logic                   ir_write,
  output logic                   exec_en,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic                   reg_write_en,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired,
  output logic                   halted
);

  state_e                 state_q, state_d;
  logic                   pc_src_q, pc_src_d;
  logic                   halted_q, halted_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;

  // MemtoReg steers the writeback mux in the datapath; the sequence of
  // states does not depend on it.
  logic unused_memtoreg;
  assign unused_memtoreg = MemtoReg;

  always_comb begin
    state_d      = state_q;
    pc_src_d     = pc_src_q;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    exec_en      = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;

    // Gating on reset keeps every enable quiet during the reset cycle, so an
    // abandoned instruction can never write the PC or bump the counter.
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              ir_write = 1'b1;
              state_d  = ST_DECODE;
            end
          end
        end

        ST_DECODE: state_d = ST_EXECUTE;

        ST_EXECUTE: begin
          exec_en  = 1'b1;
          pc_src_d = branch_taken(Uncondbranch, Branch, alu_zero);
          if (MemRead || MemWrite) begin
            state_d = ST_MEMORY;
          end else if (RegWrite) begin
            state_d = ST_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end

        ST_MEMORY: begin
          // A read takes precedence if the decoder raises both flags.
          if (MemRead) dmem_read  = 1'b1;
          else         dmem_write = 1'b1;
          if (dmem_ready) begin
            if (MemRead) begin
              state_d = ST_WRITEBACK;
            end else begin
              pc_write = 1'b1;
              state_d  = ST_FETCH;
            end
          end
        end

        ST_WRITEBACK: begin
          reg_write_en = 1'b1;
          pc_write     = 1'b1;
          state_d      = ST_FETCH;
        end

        ST_HALT: state_d = ST_HALT;

        // Unused encodings 6 and 7 fall back to FETCH.
        default: state_d = ST_FETCH;
      endcase
    end

    retired_d = retired_q + {{(COUNT_WIDTH-1){1'b0}}, pc_write};
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_src_q  <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_src_q  <= pc_src_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign pc_src  = pc_src_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule
